// File: rtl/vjtag_reg_pkg.sv
`default_nettype none
// ============================================================================
// Package : vjtag_reg_pkg
// Command and sequencer state encodings for the virtual-JTAG register access.
// Rev     : 1.0
// ============================================================================
package vjtag_reg_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_BYPASS  = 3'd0,
        CMD_ID      = 3'd1,
        CMD_ADDR    = 3'd2,
        CMD_WDATA   = 3'd3,
        CMD_RDATA   = 3'd4,
        CMD_CLR_ERR = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        HOLD   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Commands that use the full-width DR; everything else is a 1-bit bypass.
    function automatic logic is_data_cmd(input cmd_t c);
        return (c == CMD_ID) || (c == CMD_ADDR) || (c == CMD_WDATA) || (c == CMD_RDATA);
    endfunction

    function automatic logic is_commit_cmd(input cmd_t c);
        return (c == CMD_ADDR) || (c == CMD_WDATA) || (c == CMD_RDATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vjtag_if.sv
`default_nettype none
// ============================================================================
// Interface : vjtag_if
// Virtual-JTAG hub signals seen by a user instruction register / DR chain.
// Rev       : 1.0
// ============================================================================
interface vjtag_if #(
    parameter int IR_W = 3
);
    logic            tdi;
    logic            tdo;
    logic [IR_W-1:0] ir_in;
    logic [IR_W-1:0] ir_out;
    logic            virtual_state_cdr;
    logic            virtual_state_sdr;
    logic            virtual_state_e1dr;
    logic            virtual_state_pdr;
    logic            virtual_state_e2dr;
    logic            virtual_state_udr;
    logic            virtual_state_uir;

    modport in (
        input  tdi, ir_in,
        input  virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
        input  virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
        input  virtual_state_uir,
        output tdo, ir_out
    );
endinterface
`default_nettype wire

// File: rtl/vjtag_dr_shifter.sv
`default_nettype none
// ============================================================================
// Module : vjtag_dr_shifter
// DR shift register with capture load, LSB-first shift and saturating bit count.
// Rev    : 1.0
// ============================================================================
module vjtag_dr_shifter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DATA_W + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic              i_shift,
    input  logic              i_bypass,
    input  logic              i_tdi,
    output logic [DATA_W-1:0] o_sr,
    output logic [CNT_W-1:0]  o_bit_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DATA_W + 1);

    logic [DATA_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_sr      <= i_load_val;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            if (i_bypass) begin
                r_sr[0] <= i_tdi;
            end else begin
                r_sr <= {i_tdi, r_sr[DATA_W-1:1]};
            end
            // Saturate one past full length so an over-long scan never aliases to "exact".
            if (r_bit_cnt != c_cnt_max) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sr      = r_sr;
    assign o_bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire

// File: rtl/vjtag_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module : vjtag_reg_ctrl
// Virtual-JTAG command decoder and register-access sequencer (write strobes / read captures).
// Rev    : 1.0
// ============================================================================
module vjtag_reg_ctrl
    import vjtag_reg_pkg::*;
#(
    parameter int          IR_W     = 3,
    parameter int          ADDR_W   = 4,
    parameter int          DATA_W   = 16,
    parameter logic [15:0] ID_VAL   = 16'hA1A7,
    parameter bit          AUTO_INC = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    vjtag_if.in               jtag,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [DATA_W-1:0] reg_rdata_i
);

    localparam int CNT_W = $clog2(DATA_W + 2);

    state_t            r_state, w_next;
    cmd_t              r_cmd, w_ir_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err, r_ok;

    logic              w_cdr, w_sdr, w_udr, w_uir, w_pause;
    logic              w_shift, w_udr_hit, w_cnt_ok;
    logic [DATA_W-1:0] w_load_val, w_sr;
    logic [CNT_W-1:0]  w_bit_cnt;

    always_comb begin
        w_ir_cmd = CMD_BYPASS;
        if (jtag.ir_in <= IR_W'(CMD_CLR_ERR)) begin
            w_ir_cmd = cmd_t'(jtag.ir_in[CMD_W-1:0]);
        end
    end

    assign w_cdr   = jtag.virtual_state_cdr;
    assign w_sdr   = jtag.virtual_state_sdr & ~w_cdr;
    assign w_udr   = jtag.virtual_state_udr & ~w_cdr & ~jtag.virtual_state_sdr;
    assign w_uir   = jtag.virtual_state_uir & ~w_cdr & ~jtag.virtual_state_sdr
                   & ~jtag.virtual_state_udr;
    assign w_pause = (jtag.virtual_state_e1dr | jtag.virtual_state_pdr | jtag.virtual_state_e2dr)
                   & ~w_cdr & ~jtag.virtual_state_sdr & ~jtag.virtual_state_udr
                   & ~jtag.virtual_state_uir;

    // A resuming sdr out of HOLD is a real shift cycle, as in the JTAG TAP.
    assign w_shift   = w_sdr & ((r_state == SHIFT) | (r_state == HOLD));
    assign w_udr_hit = w_udr & ((r_state == SHIFT) | (r_state == HOLD));
    assign w_cnt_ok  = (w_bit_cnt == CNT_W'(DATA_W));

    always_comb begin
        w_load_val = '0;
        case (w_ir_cmd)
            CMD_ID:    w_load_val = DATA_W'(ID_VAL);
            CMD_ADDR:  w_load_val = DATA_W'(r_addr);
            CMD_RDATA: w_load_val = reg_rdata_i;
            default:   w_load_val = '0;
        endcase
    end

    vjtag_dr_shifter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dr (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_load     (w_cdr),
        .i_load_val (w_load_val),
        .i_shift    (w_shift),
        .i_bypass   (~is_data_cmd(r_cmd)),
        .i_tdi      (jtag.tdi),
        .o_sr       (w_sr),
        .o_bit_cnt  (w_bit_cnt)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = IDLE;
            SHIFT: begin
                if (w_pause)      w_next = HOLD;
                else if (w_udr)   w_next = COMMIT;
            end
            HOLD: begin
                if (w_sdr)        w_next = SHIFT;
                else if (w_udr)   w_next = COMMIT;
            end
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_cdr) begin
            w_next = SHIFT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cmd   <= CMD_BYPASS;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cdr) begin
                r_cmd <= w_ir_cmd;
            end
            if (w_udr_hit) begin
                r_ok <= w_cnt_ok & is_commit_cmd(r_cmd);
                if (is_commit_cmd(r_cmd) && !w_cnt_ok) begin
                    r_err <= 1'b1;
                end
                if ((r_cmd == CMD_WDATA) && w_cnt_ok) begin
                    r_wdata <= w_sr;
                end
            end else if (w_uir && (w_ir_cmd == CMD_CLR_ERR)) begin
                r_err <= 1'b0;
            end
            // Address moves at the end of COMMIT so the write strobe sees the pre-increment value.
            if ((r_state == COMMIT) && r_ok) begin
                case (r_cmd)
                    CMD_ADDR: r_addr <= w_sr[ADDR_W-1:0];
                    CMD_WDATA, CMD_RDATA: begin
                        if (AUTO_INC) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                    default: r_addr <= r_addr;
                endcase
            end
        end
    end

    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_wr_o    = (r_state == COMMIT) & r_ok & (r_cmd == CMD_WDATA);
    assign reg_rd_o    = w_cdr & (w_ir_cmd == CMD_RDATA) & ~rst_i;
    assign jtag.tdo    = w_sr[0];
    assign jtag.ir_out = {{(IR_W-1){1'b0}}, r_err};

endmodule
`default_nettype wire

// File: tb/tb_vjtag_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_vjtag_reg_ctrl
// Table-driven scan vectors plus hand sequences for reset and flag priority.
// Rev    : 1.0
// ============================================================================
module tb_vjtag_reg_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    typedef struct {
        logic [2:0]  ir;
        logic [15:0] din;
        int          nsh;
        int          pause_at;
        int          pause_len;
        logic [15:0] exp_tdo;
        int          exp_wr;
        logic [3:0]  exp_wr_addr;
        logic [15:0] exp_wr_data;
        int          exp_rd;
        logic [3:0]  exp_addr;
        logic [2:0]  exp_ir_out;
    } vec_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [DATA_W-1:0] reg_wdata_o;
    logic [DATA_W-1:0] reg_rdata_i;
    logic              reg_wr_o;
    logic              reg_rd_o;

    vjtag_if #(.IR_W(3)) jtag_bus ();

    vjtag_reg_ctrl #(
        .IR_W     (3),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .ID_VAL   (16'hA1A7),
        .AUTO_INC (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .jtag        (jtag_bus),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wr_o    (reg_wr_o),
        .reg_rd_o    (reg_rd_o),
        .reg_rdata_i (reg_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    logic [DATA_W-1:0] regs [16];
    assign reg_rdata_i = regs[reg_addr_o];
    always @(posedge clk_i) if (reg_wr_o) regs[reg_addr_o] <= reg_wdata_o;

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [3:0]  last_wr_addr;
    logic [15:0] last_wr_data;
    always @(negedge clk_i) begin
        if (reg_wr_o) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = reg_addr_o;
            last_wr_data = reg_wdata_o;
        end
        if (reg_rd_o) rd_cnt = rd_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_scan(input vec_t v, output logic [15:0] tdo_word);
        tdo_word = '0;
        jtag_bus.ir_in = v.ir;
        if (v.ir == 3'd5) begin
            jtag_bus.virtual_state_uir = 1'b1;
            cyc();
            jtag_bus.virtual_state_uir = 1'b0;
            cyc();
        end else begin
            jtag_bus.virtual_state_cdr = 1'b1;
            cyc();
            jtag_bus.virtual_state_cdr = 1'b0;
            for (int i = 0; i < v.nsh; i++) begin
                if (v.pause_len > 0 && i == v.pause_at) begin
                    jtag_bus.virtual_state_sdr  = 1'b0;
                    jtag_bus.virtual_state_e1dr = 1'b1;
                    cyc();
                    jtag_bus.virtual_state_e1dr = 1'b0;
                    jtag_bus.virtual_state_pdr  = 1'b1;
                    repeat (v.pause_len) cyc();
                    jtag_bus.virtual_state_pdr  = 1'b0;
                    jtag_bus.virtual_state_e2dr = 1'b1;
                    cyc();
                    jtag_bus.virtual_state_e2dr = 1'b0;
                end
                jtag_bus.virtual_state_sdr = 1'b1;
                jtag_bus.tdi = v.din[i];
                @(negedge clk_i);
                tdo_word[i] = jtag_bus.tdo;
                @(posedge clk_i);
                #1;
            end
            jtag_bus.virtual_state_sdr = 1'b0;
            jtag_bus.tdi = 1'b0;
            jtag_bus.virtual_state_udr = 1'b1;
            cyc();
            jtag_bus.virtual_state_udr = 1'b0;
            cyc();
            cyc();
        end
    endtask

    task automatic shift_bits(input logic [15:0] din, input int n);
        for (int i = 0; i < n; i++) begin
            jtag_bus.virtual_state_sdr = 1'b1;
            jtag_bus.tdi = din[i];
            cyc();
        end
        jtag_bus.virtual_state_sdr = 1'b0;
        jtag_bus.tdi = 1'b0;
    endtask

    vec_t        vecs [14];
    logic [15:0] tw;
    int          wr0, rd0;
    vec_t        s;

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = '0;
        regs[7] = 16'h5A5A;
        jtag_bus.tdi = 1'b0;
        jtag_bus.ir_in = 3'd0;
        jtag_bus.virtual_state_cdr  = 1'b0;
        jtag_bus.virtual_state_sdr  = 1'b0;
        jtag_bus.virtual_state_e1dr = 1'b0;
        jtag_bus.virtual_state_pdr  = 1'b0;
        jtag_bus.virtual_state_e2dr = 1'b0;
        jtag_bus.virtual_state_udr  = 1'b0;
        jtag_bus.virtual_state_uir  = 1'b0;
        rst_i = 1'b1;
        repeat (3) cyc();
        check("reset_addr",   32'(reg_addr_o),      32'h0);
        check("reset_wr",     32'(reg_wr_o),        32'h0);
        check("reset_rd",     32'(reg_rd_o),        32'h0);
        check("reset_tdo",    32'(jtag_bus.tdo),    32'h0);
        check("reset_ir_out", 32'(jtag_bus.ir_out), 32'h0);
        rst_i = 1'b0;
        cyc();

        //          ir     din       nsh pa pl tdo       wr wa     wd        rd addr   ir_out
        vecs[0]  = '{3'd1, 16'h0000, 16, 0, 0, 16'hA1A7, 0, 4'd0,  16'h0000, 0, 4'd0,  3'd0};
        vecs[1]  = '{3'd2, 16'h0003, 16, 0, 0, 16'h0000, 0, 4'd0,  16'h0000, 0, 4'd3,  3'd0};
        vecs[2]  = '{3'd3, 16'h1234, 16, 0, 0, 16'h0000, 1, 4'd3,  16'h1234, 0, 4'd4,  3'd0};
        vecs[3]  = '{3'd3, 16'hBEEF, 16, 0, 0, 16'h0000, 1, 4'd4,  16'hBEEF, 0, 4'd5,  3'd0};
        vecs[4]  = '{3'd2, 16'h0007, 16, 0, 0, 16'h0005, 0, 4'd0,  16'h0000, 0, 4'd7,  3'd0};
        vecs[5]  = '{3'd4, 16'h0000, 16, 0, 0, 16'h5A5A, 0, 4'd0,  16'h0000, 1, 4'd8,  3'd0};
        vecs[6]  = '{3'd3, 16'hFFFF, 15, 0, 0, 16'h0000, 0, 4'd0,  16'h0000, 0, 4'd8,  3'd1};
        vecs[7]  = '{3'd5, 16'h0000, 0,  0, 0, 16'h0000, 0, 4'd0,  16'h0000, 0, 4'd8,  3'd0};
        vecs[8]  = '{3'd0, 16'h000B, 4,  0, 0, 16'h0006, 0, 4'd0,  16'h0000, 0, 4'd8,  3'd0};
        vecs[9]  = '{3'd2, 16'h000F, 16, 0, 0, 16'h0008, 0, 4'd0,  16'h0000, 0, 4'd15, 3'd0};
        vecs[10] = '{3'd3, 16'hC3A5, 16, 8, 5, 16'h0000, 1, 4'd15, 16'hC3A5, 0, 4'd0,  3'd0};
        vecs[11] = '{3'd6, 16'h0001, 2,  0, 0, 16'h0002, 0, 4'd0,  16'h0000, 0, 4'd0,  3'd0};
        vecs[12] = '{3'd2, 16'h0003, 16, 0, 0, 16'h0000, 0, 4'd0,  16'h0000, 0, 4'd3,  3'd0};
        vecs[13] = '{3'd4, 16'h0000, 16, 0, 0, 16'h1234, 0, 4'd0,  16'h0000, 1, 4'd4,  3'd0};

        for (int k = 0; k < 14; k++) begin
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            run_scan(vecs[k], tw);
            if (vecs[k].nsh > 0) check($sformatf("v%0d_tdo", k), 32'(tw), 32'(vecs[k].exp_tdo));
            check($sformatf("v%0d_wr_count", k), 32'(wr_cnt - wr0), 32'(vecs[k].exp_wr));
            if (vecs[k].exp_wr > 0) begin
                check($sformatf("v%0d_wr_addr", k), 32'(last_wr_addr), 32'(vecs[k].exp_wr_addr));
                check($sformatf("v%0d_wr_data", k), 32'(last_wr_data), 32'(vecs[k].exp_wr_data));
            end
            check($sformatf("v%0d_rd_count", k), 32'(rd_cnt - rd0), 32'(vecs[k].exp_rd));
            check($sformatf("v%0d_addr", k), 32'(reg_addr_o), 32'(vecs[k].exp_addr));
            check($sformatf("v%0d_ir_out", k), 32'(jtag_bus.ir_out), 32'(vecs[k].exp_ir_out));
        end

        // Short scan raises err, then a reset in the middle of a WDATA scan clears everything.
        s = '{3'd3, 16'hFFFF, 3, 0, 0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 3'd0};
        run_scan(s, tw);
        check("short_ir_out", 32'(jtag_bus.ir_out), 32'h1);
        wr0 = wr_cnt;
        jtag_bus.ir_in = 3'd3;
        jtag_bus.virtual_state_cdr = 1'b1;
        cyc();
        jtag_bus.virtual_state_cdr = 1'b0;
        shift_bits(16'hFFFF, 8);
        jtag_bus.virtual_state_sdr = 1'b1;
        rst_i = 1'b1;
        #1;
        check("rst_mid_addr",   32'(reg_addr_o),      32'h0);
        check("rst_mid_ir_out", 32'(jtag_bus.ir_out), 32'h0);
        check("rst_mid_wr",     32'(reg_wr_o),        32'h0);
        cyc();
        cyc();
        jtag_bus.virtual_state_sdr = 1'b0;
        rst_i = 1'b0;
        cyc();
        shift_bits(16'hFFFF, 8);
        jtag_bus.virtual_state_udr = 1'b1;
        cyc();
        jtag_bus.virtual_state_udr = 1'b0;
        cyc();
        cyc();
        check("rst_after_wr_count", 32'(wr_cnt - wr0),    32'h0);
        check("rst_after_ir_out",   32'(jtag_bus.ir_out), 32'h0);
        check("rst_after_addr",     32'(reg_addr_o),      32'h0);

        // cdr and udr in the same cycle: the scan restarts and nothing commits.
        jtag_bus.ir_in = 3'd2;
        jtag_bus.virtual_state_cdr = 1'b1;
        cyc();
        jtag_bus.virtual_state_cdr = 1'b0;
        shift_bits(16'h0009, 16);
        jtag_bus.virtual_state_cdr = 1'b1;
        jtag_bus.virtual_state_udr = 1'b1;
        cyc();
        jtag_bus.virtual_state_cdr = 1'b0;
        jtag_bus.virtual_state_udr = 1'b0;
        cyc();
        check("prio_no_commit_addr", 32'(reg_addr_o), 32'h0);
        shift_bits(16'h0002, 16);
        jtag_bus.virtual_state_udr = 1'b1;
        cyc();
        jtag_bus.virtual_state_udr = 1'b0;
        cyc();
        cyc();
        check("prio_restart_addr",   32'(reg_addr_o),      32'h2);
        check("prio_restart_ir_out", 32'(jtag_bus.ir_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
